// File: rtl/md_unit_ctrl.sv
// rtl/md_unit_ctrl.sv - multi-cycle multiply/divide scheduler owning the HI/LO register pair
module md_unit_ctrl #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             md_use,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   a_mag, b_mag, div_s_by, div_u_by;
    logic [WIDTH-1:0]   quo_mag, rem_mag, quo_s, rem_s, quo_u, rem_u;

    // Signed divide works on magnitudes so the most-negative / -1 case needs no special handling.
    always_comb begin
        prod_s   = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
        prod_u   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        a_mag    = a_q[WIDTH-1] ? -a_q : a_q;
        b_mag    = b_q[WIDTH-1] ? -b_q : b_q;
        div_s_by = (b_mag == '0) ? WIDTH'(1) : b_mag;
        div_u_by = (b_q == '0) ? WIDTH'(1) : b_q;
        quo_mag  = a_mag / div_s_by;
        rem_mag  = a_mag % div_s_by;
        quo_s    = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -quo_mag : quo_mag;
        rem_s    = a_q[WIDTH-1] ? -rem_mag : rem_mag;
        quo_u    = a_q / div_u_by;
        rem_u    = a_q % div_u_by;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!op[2]) begin
                        op_d    = op[1:0];
                        a_d     = a;
                        b_d     = b;
                        cnt_d   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        state_d = BUSY;
                    end else if (op == 3'd4) begin
                        hi_d = a;
                    end else if (op == 3'd5) begin
                        lo_d = a;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    case (op_q)
                        2'd0: {hi_d, lo_d} = prod_s;
                        2'd1: {hi_d, lo_d} = prod_u;
                        2'd2: if (b_q != '0) begin
                            hi_d = rem_s;
                            lo_d = quo_s;
                        end
                        default: if (b_q != '0) begin
                            hi_d = rem_u;
                            lo_d = quo_u;
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy  = (state_q == BUSY);
    assign stall = md_use & (busy | (start & ~op[2]));
    assign hi    = hi_q;
    assign lo    = lo_q;
endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb/tb_md_unit_ctrl.sv - scoreboard bench for md_unit_ctrl against a behavioural HI/LO model
module tb_md_unit_ctrl;
    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         md_use = 1'b0;
    logic [2:0]   op = 3'd7;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, stall;
    logic [W-1:0] hi, lo;

    md_unit_ctrl #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .md_use(md_use), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           len;
    } exp_t;
    exp_t q[$];

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every falling edge of busy is a commit (or abort) that must match the queue head.
    bit prev_busy = 1'b0;
    int run = 0;
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            run++;
        end else if (prev_busy) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit: got busy fall with hi=%0h lo=%0h expected none", hi, lo);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("commit_hi", hi, e.hi);
                chk("commit_lo", lo, e.lo);
                chk("busy_len", run, e.len);
            end
            run = 0;
        end
        prev_busy = (busy === 1'b1);
    end

    // Reference: plain 64-bit arithmetic; returns {changed, hi, lo}.
    function automatic logic [64:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint          sx, sy, qq, rr;
        longint unsigned ux, uy, uq, ur;
        logic [63:0]     r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        case (o)
            3'd0: r = sx * sy;
            3'd1: r = ux * uy;
            3'd2: begin
                if (y == 0) return {1'b0, m_hi, m_lo};
                qq = sx / sy;
                rr = sx % sy;
                r  = {rr[31:0], qq[31:0]};
            end
            default: begin
                if (y == 0) return {1'b0, m_hi, m_lo};
                uq = ux / uy;
                ur = ux % uy;
                r  = {ur[31:0], uq[31:0]};
            end
        endcase
        return {1'b1, r};
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit inject);
        logic [64:0] r;
        int          n;
        int          exp_len;
        op     = o;
        a      = x;
        b      = y;
        start  = 1'b1;
        md_use = 1'($urandom_range(0, 1));
        #1;
        chk("stall_issue", stall, md_use & (o <= 3'd3));
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'($urandom_range(0, 7));
        a     = $urandom;
        b     = $urandom;
        if (o <= 3'd3) begin
            r       = model(o, x, y);
            exp_len = (o <= 3'd1) ? MC : DC;
            q.push_back('{r[63:32], r[31:0], exp_len});
            n = 0;
            while (busy === 1'b1 && n < 100) begin
                md_use = 1'($urandom_range(0, 1));
                if (inject && n == 2) begin
                    start = 1'b1;
                    op    = 3'($urandom_range(0, 5));
                end
                #1;
                chk("stall_busy", stall, md_use);
                chk("hold_hi", hi, m_hi);
                chk("hold_lo", lo, m_lo);
                @(posedge clk);
                #1;
                start = 1'b0;
                n++;
            end
            chk("busy_cycles", n, exp_len);
            if (r[64]) begin
                m_hi = r[63:32];
                m_lo = r[31:0];
            end
        end else begin
            if (o == 3'd4) m_hi = x;
            if (o == 3'd5) m_lo = x;
            chk("idle_busy", busy, 1'b0);
        end
        chk("after_hi", hi, m_hi);
        chk("after_lo", lo, m_lo);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_hi", hi, '0);
        chk("reset_lo", lo, '0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_op(3'd4, 32'h1234, 32'h0, 1'b0);
        run_op(3'd5, 32'h5678, 32'h0, 1'b0);
        chk("mthi_value", hi, 32'h1234);
        chk("mtlo_value", lo, 32'h5678);

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("multu_hi", hi, 32'h2);
        chk("multu_lo", lo, 32'hFFFF_FFFA);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        run_op(3'd3, 32'd7, 32'd0, 1'b0);
        chk("divu0_hi", hi, 32'hFFFF_FFFF);
        chk("divu0_lo", lo, 32'hFFFF_FFFD);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("divovf_hi", hi, 32'h0);
        chk("divovf_lo", lo, 32'h8000_0000);

        run_op(3'd0, 32'h0001_2345, 32'hFFFF_0011, 1'b1);
        run_op(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        run_op(3'd2, 32'd1000, 32'hFFFF_FFFD, 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic [2:0]   o;
            logic [W-1:0] x, y;
            o = 3'($urandom_range(0, 7));
            x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            y = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(1, 9));
            run_op(o, x, y, 1'($urandom_range(0, 1)));
        end

        run_op(3'd4, 32'hDEAD_BEEF, 32'h0, 1'b0);
        op     = 3'd2;
        a      = 32'd100;
        b      = 32'd7;
        start  = 1'b1;
        md_use = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'd7;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        q.push_back('{32'h0, 32'h0, 4});
        m_hi = '0;
        m_lo = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_hi", hi, '0);
        chk("abort_lo", lo, '0);
        repeat (12) @(posedge clk);
        #1;
        chk("abort_late_busy", busy, 1'b0);
        chk("abort_late_hi", hi, '0);
        chk("abort_late_lo", lo, '0);
        chk("queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
